// File: rtl/pwr_pkg.sv
// Power-state and sequencer encodings shared by the power-management blocks.
// Deeper states are numerically larger, so plain compares order them.
package pwr_pkg;

  typedef enum logic [1:0] {
    PWR_ACTIVE = 2'b00,
    PWR_IDLE   = 2'b01,
    PWR_SLEEP  = 2'b10,
    PWR_OFF    = 2'b11
  } pwr_state_t;

  typedef enum logic [1:0] {
    SEQ_STABLE   = 2'b00,
    SEQ_QUIESCE  = 2'b01,
    SEQ_WAIT_ACK = 2'b10,
    SEQ_HOLD     = 2'b11
  } seq_state_t;

  localparam int CNT_W = 16;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/pwr_vote_resolver.sv
// Shallowest-wins reduction over the valid votes, ties go to the lowest index.
// Latency: combinational; the parent registers the result.
// Backpressure: none, votes are level inputs sampled every cycle.
module pwr_vote_resolver
  import pwr_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int ID_W    = 2
) (
  input  logic [2*NUM_REQ-1:0] vote,
  input  logic [NUM_REQ-1:0]   vote_valid,
  output logic [1:0]           state,
  output logic [ID_W-1:0]      id
);

  logic found;

  always_comb begin
    state = PWR_ACTIVE;
    id    = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      // strict compare keeps the earliest requester on a tie
      if (vote_valid[k] && (!found || (vote[2*k +: 2] < state))) begin
        state = vote[2*k +: 2];
        id    = ID_W'(k);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pwr_state_sequencer.sv
// Resolves requester votes into a power target and sequences power_mgmt through it.
// Latency: target/grant 1 cycle after votes; deepening waits QUIESCE_CYCLES idle cycles.
// Backpressure: none upstream; waits up to ACK_TIMEOUT for power_mgmt ack, then dwells HOLD_CYCLES.
module pwr_state_sequencer
  import pwr_pkg::*;
#(
  parameter int  NUM_REQ        = 3,
  parameter int  QUIESCE_CYCLES = 16,
  parameter int  ACK_TIMEOUT    = 2048,
  parameter int  HOLD_CYCLES    = 32,
  localparam int ID_W           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 i_sys_clk,
  input  logic                 i_rst_n,
  input  logic [2*NUM_REQ-1:0] i_vote,
  input  logic [NUM_REQ-1:0]   i_vote_valid,
  input  logic                 i_core_busy,
  input  logic [1:0]           i_pwr_ack,
  input  logic                 i_wake_event,
  input  logic                 i_err_clr,
  output logic [1:0]           o_pwr_req,
  output logic                 o_wake_up_en,
  output logic [1:0]           o_target_state,
  output logic [ID_W-1:0]      o_grant_id,
  output logic                 o_busy,
  output logic                 o_timeout_err
);

  localparam logic [CNT_W-1:0] Q_LAST = CNT_W'(QUIESCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] A_LAST = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(HOLD_CYCLES - 1);

  logic [1:0]       res_state;
  logic [ID_W-1:0]  res_id;
  seq_state_t       state_q;
  logic [1:0]       committed_q;
  logic [1:0]       pending_q;
  logic [CNT_W-1:0] qcnt_q;
  logic [CNT_W-1:0] acnt_q;
  logic [CNT_W-1:0] hcnt_q;

  pwr_vote_resolver #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_resolver (
    .vote       (i_vote),
    .vote_valid (i_vote_valid),
    .state      (res_state),
    .id         (res_id)
  );

  assign o_busy = (state_q != SEQ_STABLE);

  // FSM decisions use the live resolution so the request lines up with o_target_state
  always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q        <= SEQ_STABLE;
      committed_q    <= PWR_ACTIVE;
      pending_q      <= PWR_ACTIVE;
      qcnt_q         <= '0;
      acnt_q         <= '0;
      hcnt_q         <= '0;
      o_pwr_req      <= PWR_ACTIVE;
      o_wake_up_en   <= 1'b0;
      o_target_state <= PWR_ACTIVE;
      o_grant_id     <= '0;
      o_timeout_err  <= 1'b0;
    end else begin
      o_target_state <= res_state;
      o_grant_id     <= res_id;
      if (i_err_clr) o_timeout_err <= 1'b0;

      if (i_wake_event) begin
        committed_q  <= PWR_ACTIVE;
        o_pwr_req    <= PWR_ACTIVE;
        o_wake_up_en <= 1'b0;
        hcnt_q       <= '0;
        state_q      <= SEQ_HOLD;
      end else begin
        unique case (state_q)
          SEQ_STABLE: begin
            o_pwr_req <= committed_q;
            if (res_state > committed_q) begin
              qcnt_q  <= '0;
              state_q <= SEQ_QUIESCE;
            end else if (res_state < committed_q) begin
              // leaving OFF always goes through ACTIVE with the wake path enabled
              pending_q    <= (committed_q == PWR_OFF) ? PWR_ACTIVE : res_state;
              o_pwr_req    <= (committed_q == PWR_OFF) ? PWR_ACTIVE : res_state;
              o_wake_up_en <= (committed_q == PWR_OFF);
              acnt_q       <= '0;
              state_q      <= SEQ_WAIT_ACK;
            end
          end
          SEQ_QUIESCE: begin
            if (res_state <= committed_q) begin
              state_q <= SEQ_STABLE;
            end else if (i_core_busy) begin
              qcnt_q <= '0;
            end else if (qcnt_q >= Q_LAST) begin
              pending_q <= res_state;
              o_pwr_req <= res_state;
              acnt_q    <= '0;
              state_q   <= SEQ_WAIT_ACK;
            end else begin
              qcnt_q <= sat_inc(qcnt_q);
            end
          end
          SEQ_WAIT_ACK: begin
            if (i_pwr_ack == pending_q) begin
              committed_q  <= pending_q;
              o_wake_up_en <= 1'b0;
              hcnt_q       <= '0;
              state_q      <= SEQ_HOLD;
            end else if (acnt_q >= A_LAST) begin
              o_timeout_err <= 1'b1;
              o_pwr_req     <= PWR_ACTIVE;
              committed_q   <= PWR_ACTIVE;
              o_wake_up_en  <= 1'b0;
              hcnt_q        <= '0;
              state_q       <= SEQ_HOLD;
            end else begin
              acnt_q <= sat_inc(acnt_q);
            end
          end
          SEQ_HOLD: begin
            if ((res_state < committed_q) || (hcnt_q >= H_LAST)) begin
              state_q <= SEQ_STABLE;
            end else begin
              hcnt_q <= sat_inc(hcnt_q);
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pwr_state_sequencer.sv
// Scoreboard bench: stimulus queues every expected output change with its cycle,
// the monitor pops one entry per observed change of the output bundle.
module tb_pwr_state_sequencer;

  logic       i_sys_clk    = 1'b0;
  logic       i_rst_n      = 1'b0;
  logic [5:0] i_vote       = '0;
  logic [2:0] i_vote_valid = '0;
  logic       i_core_busy  = 1'b0;
  logic [1:0] i_pwr_ack    = 2'b00;
  logic       i_wake_event = 1'b0;
  logic       i_err_clr    = 1'b0;
  logic [1:0] o_pwr_req;
  logic       o_wake_up_en;
  logic [1:0] o_target_state;
  logic [1:0] o_grant_id;
  logic       o_busy;
  logic       o_timeout_err;

  pwr_state_sequencer dut (
    .i_sys_clk      (i_sys_clk),
    .i_rst_n        (i_rst_n),
    .i_vote         (i_vote),
    .i_vote_valid   (i_vote_valid),
    .i_core_busy    (i_core_busy),
    .i_pwr_ack      (i_pwr_ack),
    .i_wake_event   (i_wake_event),
    .i_err_clr      (i_err_clr),
    .o_pwr_req      (o_pwr_req),
    .o_wake_up_en   (o_wake_up_en),
    .o_target_state (o_target_state),
    .o_grant_id     (o_grant_id),
    .o_busy         (o_busy),
    .o_timeout_err  (o_timeout_err)
  );

  always #5 i_sys_clk = ~i_sys_clk;

  typedef struct packed {
    logic [1:0] req;
    logic       wue;
    logic [1:0] tgt;
    logic [1:0] gid;
    logic       busy;
    logic       terr;
  } obs_t;

  typedef struct {
    int    cyc_at;
    obs_t  v;
    string tag;
  } exp_t;

  exp_t sb[$];
  obs_t exp_o;
  obs_t cur_o;
  obs_t prev_o;
  exp_t e;
  bit   have_prev = 1'b0;
  bit   done      = 1'b0;
  int   cyc       = 0;
  int   checks    = 0;
  int   errors    = 0;

  always @(posedge i_sys_clk) cyc <= cyc + 1;

  // power_mgmt stand-in: acknowledges the request three cycles later
  bit         ack_en = 1'b1;
  logic [1:0] ack_pipe [3] = '{2'b00, 2'b00, 2'b00};
  always @(negedge i_sys_clk) begin
    if (ack_en) begin
      ack_pipe[2] = ack_pipe[1];
      ack_pipe[1] = ack_pipe[0];
      ack_pipe[0] = o_pwr_req;
      i_pwr_ack   = ack_pipe[2];
    end
  end

  always @(negedge i_sys_clk) begin
    cur_o = {o_pwr_req, o_wake_up_en, o_target_state, o_grant_id, o_busy, o_timeout_err};
    if (!have_prev || (cur_o !== prev_o)) begin
      have_prev = 1'b1;
      prev_o    = cur_o;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_change cyc=%0d actual=%h required=no change", cyc, cur_o);
      end else begin
        e = sb.pop_front();
        if (cur_o !== e.v) begin
          errors++;
          $display("FAIL %s value cyc=%0d actual=%h required=%h", e.tag, cyc, cur_o, e.v);
        end
        if (e.cyc_at >= 0) begin
          checks++;
          if (cyc != e.cyc_at) begin
            errors++;
            $display("FAIL %s cycle actual=%0d required=%0d", e.tag, cyc, e.cyc_at);
          end
        end
      end
    end
    if (done) begin
      checks++;
      if (sb.size() != 0) begin
        errors++;
        $display("FAIL sb_drain actual=%0d pending required=0 (next %s)", sb.size(), sb[0].tag);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge i_sys_clk);
  endtask

  task automatic expect_at(input int at, input string tag);
    exp_t x;
    x.cyc_at = at;
    x.v      = exp_o;
    x.tag    = tag;
    sb.push_back(x);
  endtask

  initial begin
    int t;
    exp_o = '0;
    expect_at(-1, "reset");
    tick(4);
    i_rst_n = 1'b1;
    tick(4);

    // vote resolution, busy held so the quiesce never completes
    t = cyc; i_core_busy = 1'b1; i_vote = {2'b10, 2'b00, 2'b01}; i_vote_valid = 3'b101;
    exp_o.tgt = 2'b01; exp_o.gid = 2'd0; exp_o.busy = 1'b1; expect_at(t + 1, "res_min");
    tick(4); t = cyc; i_vote_valid = 3'b100;
    exp_o.tgt = 2'b10; exp_o.gid = 2'd2; expect_at(t + 1, "res_single");
    tick(4); t = cyc; i_vote = {2'b01, 2'b01, 2'b00}; i_vote_valid = 3'b110;
    exp_o.tgt = 2'b01; exp_o.gid = 2'd1; expect_at(t + 1, "res_tie");
    tick(4); t = cyc; i_vote_valid = 3'b000;
    exp_o.tgt = 2'b00; exp_o.gid = 2'd0; exp_o.busy = 1'b0; expect_at(t + 1, "res_none");
    tick(1); i_core_busy = 1'b0; tick(3);

    // deepen ACTIVE -> SLEEP
    t = cyc; i_vote = {2'b00, 2'b10, 2'b00}; i_vote_valid = 3'b010;
    exp_o.tgt = 2'b10; exp_o.gid = 2'd1; exp_o.busy = 1'b1; expect_at(t + 1, "deep_start");
    exp_o.req = 2'b10; expect_at(t + 17, "deep_req");
    exp_o.busy = 1'b0; expect_at(t + 52, "deep_hold_end");
    tick(60);

    // retract a deeper vote mid-quiesce
    t = cyc; i_vote[3:2] = 2'b11;
    exp_o.tgt = 2'b11; exp_o.busy = 1'b1; expect_at(t + 1, "abort_start");
    tick(6); t = cyc; i_vote[3:2] = 2'b10;
    exp_o.tgt = 2'b10; exp_o.busy = 1'b0; expect_at(t + 1, "abort_stable");
    tick(30);

    // ack never arrives; err_clr coincides with the timeout edge
    t = cyc; ack_en = 1'b0; i_vote[3:2] = 2'b11;
    exp_o.tgt = 2'b11; exp_o.busy = 1'b1; expect_at(t + 1, "to_start");
    exp_o.req = 2'b11; expect_at(t + 17, "to_req");
    exp_o.req = 2'b00; exp_o.terr = 1'b1; expect_at(t + 2065, "to_fire");
    tick(2064); i_err_clr = 1'b1; tick(1); i_err_clr = 1'b0;
    tick(5); i_vote_valid = 3'b000;
    exp_o.tgt = 2'b00; exp_o.gid = 2'd0; expect_at(t + 2071, "to_vote_drop");
    exp_o.busy = 1'b0; expect_at(t + 2097, "to_hold_end");
    tick(30); i_err_clr = 1'b1;
    exp_o.terr = 1'b0; expect_at(t + 2101, "to_err_clr");
    tick(1); i_err_clr = 1'b0; ack_en = 1'b1; tick(8);

    // busy pulse restarts the quiesce count
    t = cyc; i_vote = {2'b00, 2'b10, 2'b00}; i_vote_valid = 3'b010;
    exp_o.tgt = 2'b10; exp_o.gid = 2'd1; exp_o.busy = 1'b1; expect_at(t + 1, "qr_start");
    tick(10); i_core_busy = 1'b1; tick(1); i_core_busy = 1'b0;
    exp_o.req = 2'b10; expect_at(t + 27, "qr_req");
    exp_o.busy = 1'b0; expect_at(t + 62, "qr_hold_end");
    tick(60);

    // wake event out of SLEEP, then SLEEP is re-requested after hold + quiesce
    t = cyc; i_wake_event = 1'b1;
    exp_o.req = 2'b00; exp_o.busy = 1'b1; expect_at(t + 1, "wk_active");
    tick(1); i_wake_event = 1'b0;
    exp_o.busy = 1'b0; expect_at(t + 33, "wk_hold_end");
    exp_o.busy = 1'b1; expect_at(t + 34, "wk_requiesce");
    exp_o.req = 2'b10; expect_at(t + 50, "wk_rereq");
    exp_o.busy = 1'b0; expect_at(t + 85, "wk_settle");
    tick(90);

    // deepen SLEEP -> OFF
    t = cyc; i_vote[3:2] = 2'b11;
    exp_o.tgt = 2'b11; exp_o.busy = 1'b1; expect_at(t + 1, "off_start");
    exp_o.req = 2'b11; expect_at(t + 17, "off_req");
    exp_o.busy = 1'b0; expect_at(t + 52, "off_hold_end");
    tick(56);

    // leave OFF via ack
    t = cyc; i_vote[1:0] = 2'b00; i_vote_valid = 3'b011;
    exp_o.tgt = 2'b00; exp_o.gid = 2'd0; exp_o.req = 2'b00; exp_o.wue = 1'b1; exp_o.busy = 1'b1;
    expect_at(t + 1, "exoff_req");
    exp_o.wue = 1'b0; expect_at(t + 4, "exoff_ack");
    exp_o.busy = 1'b0; expect_at(t + 36, "exoff_hold_end");
    tick(40);

    // back to OFF, then leave OFF via wake event with ack stalled
    t = cyc; i_vote_valid = 3'b010;
    exp_o.tgt = 2'b11; exp_o.gid = 2'd1; exp_o.busy = 1'b1; expect_at(t + 1, "off2_start");
    exp_o.req = 2'b11; expect_at(t + 17, "off2_req");
    exp_o.busy = 1'b0; expect_at(t + 52, "off2_hold_end");
    tick(55); ack_en = 1'b0; tick(1);
    t = cyc; i_vote_valid = 3'b011;
    exp_o.tgt = 2'b00; exp_o.gid = 2'd0; exp_o.req = 2'b00; exp_o.wue = 1'b1; exp_o.busy = 1'b1;
    expect_at(t + 1, "exoff2_req");
    tick(5); i_wake_event = 1'b1;
    exp_o.wue = 1'b0; expect_at(t + 6, "exoff2_wake");
    tick(1); i_wake_event = 1'b0;
    exp_o.busy = 1'b0; expect_at(t + 38, "exoff2_hold_end");
    tick(40); ack_en = 1'b1; tick(4);

    // asynchronous reset in the middle of a quiesce
    t = cyc; i_vote_valid = 3'b010;
    exp_o.tgt = 2'b11; exp_o.gid = 2'd1; exp_o.busy = 1'b1; expect_at(t + 1, "rst_quiesce");
    tick(5);
    #2;
    i_rst_n = 1'b0; i_vote_valid = 3'b000;
    exp_o = '0; expect_at(t + 6, "rst_mid");
    tick(3); i_rst_n = 1'b1; tick(5);
    done = 1'b1;
  end

  initial begin
    #300000;
    $display("FAIL watchdog cyc=%0d required=run to summary", cyc);
    $fatal(1);
  end

endmodule
